fdiv_seq: RTL and testbench
===========================

// Module: fdiv_seq
// PURPOSE
//  Iterative IEEE-754 single-precision divider, y = a / b, with valid/ready handshakes on both sides.
//  Companion to the combinational faddV adder: same operand format and same z/n/c/o flag set.
//  One restoring-division quotient bit per cycle. Sits in the FP datapath beside faddV.
// PARAMETERS
//  QBITS   26  quotient bits produced: 24 significand + 1 normalisation + 1 guard
// PORTS
//  clk        in   1   system clock; all state changes on rising edge
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   divider can accept operands
//  a          in   32  dividend, fp32
//  b          in   32  divisor, fp32
//  out_valid  out  1   result y and flags valid
//  out_ready  in   1   consumer accepts result
//  y          out  32  quotient, fp32
//  z          out  1   result is +/-0
//  n          out  1   result sign bit
//  c          out  1   divide-by-zero (finite nonzero a, zero b)
//  o          out  1   exponent overflow or underflow (result forced to inf/0)
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0; y=0; z=n=c=o=0; in_ready=0 while rst=1, else 1 in IDLE.
//  - rst mid-operation aborts; nothing is output; any pending result is discarded.
//  - States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE. Special operands go IDLE -> DONE.
//  - in_ready=1 only in IDLE. Accept on in_valid&&in_ready at edge k; latch a, b.
//  - Subnormal inputs flush to signed zero. Result sign sa^sb, including zero and inf results.
//  - Special cases, resolved at accept edge; out_valid from k+1:
//    NaN in, 0/0, or inf/inf -> 0x7FC00000.
//    x/0 (x finite, nonzero) -> signed inf, c=1.
//    inf/x -> signed inf.  0/x or x/inf -> signed 0, z=1.
//  - Normal path:
//    exp = ea - eb + 127, 10-bit signed.
//    DIVIDE runs 26 cycles (k+1..k+26) on {1,ma}/{1,mb}, 5-bit counter 25..0.
//    NORM at k+27: if q[25]=0, shift q left 1 and exp-1; then round.
//    out_valid from k+28. Total normal latency 28 cycles.
//  - Range: exp>=255 -> signed inf, o=1. exp<=0 -> signed 0, o=1, z=1.
//  - DONE: y and flags held stable while out_valid=1 and out_ready=0.
//    On out_valid&&out_ready go to IDLE; in_ready=1 the next cycle. No overlap of operations.
//  - n always equals y[31]. z=1 iff y[30:0]==0.
// CONFIGURATION
//  FDIV_ROUND_NEAREST_EN defined:
//    round-to-nearest-even. guard = q bit below LSB; sticky = nonzero remainder.
//    Mantissa carry-out increments exp, re-checked for overflow.
//  Not defined: truncate toward zero. Guard and sticky ignored. Same latency.
// STRUCTURE
//  Package fp32_pkg:
//    field widths (SIGN=1, EXP_W=8, MAN_W=23), BIAS=127.
//    constants QNAN=32'h7FC00000, POS_INF=32'h7F800000.
//    state enum {IDLE, DIVIDE, NORM, DONE}.
//  Sub-module fdiv_mant_core: 24-bit restoring divider, start/busy/done, quotient + remainder outputs.
//  Top holds classification, exponent, NORM/round and handshake FSM.
// TESTING
//  - 0x40C00000 / 0x3FC00000 (6/1.5) -> y=0x40800000, out_valid exactly 28 cycles after accept, flags 0.
//  - 0x3F800000 / 0x40400000 (1/3) -> y=0x3EAAAAAB with _EN, 0x3EAAAAAA without.
//  - 0xC10AB852 / 0x410AB852 (-8.67/8.67) -> y=0xBF800000, n=1.
//  - 0x40A00000 / 0x00000000 -> y=0x7F800000, c=1, out_valid at k+1.
//  - 0/0 -> y=0x7FC00000.
//  - 0x7F000000 / 0x3E800000 -> y=0x7F800000, o=1.
//  - Hold out_ready=0 for 5 cycles: y and flags stable, in_ready=0.
//    Assert rst at DIVIDE cycle 10: out_valid never rises; in_ready=1 one cycle after rst drops.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg: single-precision field layout, special constants and divider FSM states.
// FDIV_ROUND_NEAREST_EN selects round-to-nearest-even in round_increment(); otherwise truncation.
package fp32_pkg;

    localparam int SIGN  = 1;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int QBITS = 26;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_e;

    typedef struct packed {
        logic [SIGN-1:0]  sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // A zero exponent field covers both true zero and subnormals, which flush to zero.
    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        fp_class_t k;
        k.zero = (e == '0);
        k.inf  = (e == '1) && (m == '0);
        k.nan  = (e == '1) && (m != '0);
        return k;
    endfunction

    function automatic logic round_increment(input logic lsb, input logic guard, input logic sticky);
`ifdef FDIV_ROUND_NEAREST_EN
        return guard & (sticky | lsb);
`else
        return 1'b0;
`endif
    endfunction

endpackage

// File: rtl/fdiv_mant_core.sv
// fdiv_mant_core: restoring divider on two 24-bit significands, one quotient bit per clock.
// done_o is high during the cycle whose closing edge takes the final quotient bit.
module fdiv_mant_core
    import fp32_pkg::*;
#(
    parameter int QBITS_P = QBITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [MAN_W:0]     dividend_i,
    input  logic [MAN_W:0]     divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [QBITS_P-1:0] quot_o,
    output logic [MAN_W+1:0]   rem_o
);

    localparam int CNT_W = $clog2(QBITS_P);

    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAN_W+1:0]   rem_q, rem_d;
    logic [MAN_W:0]     div_q, div_d;
    logic [QBITS_P-1:0] quot_q, quot_d;
    logic [MAN_W+1:0]   trial;
    logic               take;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        div_d  = div_q;
        quot_d = quot_q;
        take   = (rem_q >= {1'b0, div_q});
        trial  = rem_q - {1'b0, div_q};
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(QBITS_P - 1);
            rem_d  = {1'b0, dividend_i};
            div_d  = divisor_i;
            quot_d = '0;
        end else if (busy_q) begin
            // Remainder stays below twice the divisor, so 25 bits never overflow.
            quot_d = {quot_q[QBITS_P-2:0], take};
            rem_d  = (take ? trial : rem_q) << 1;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == '0) busy_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: datapath registers are left unreset; they are always loaded by start_i before being read.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        div_q  <= div_d;
        quot_q <= quot_d;
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative fp32 divider y = a / b with valid/ready on both sides and z/n/c/o flags.
// Define FDIV_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module fdiv_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        z,
    output logic        n,
    output logic        c,
    output logic        o
);

    localparam logic signed [9:0] EXP_MAX = 10'sd255;

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [31:0]       y_q, y_d;
    logic              z_q, z_d, n_q, n_d, c_q, c_d, o_q, o_d;

    fp32_t             fa, fb;
    fp_class_t         ca, cb;
    logic              sign_in, accept;
    logic              spec_hit, spec_c;
    logic [31:0]       spec_y;

    logic              core_start, core_busy, core_done;
    logic [QBITS-1:0]  quot;
    logic [MAN_W+1:0]  rem;

    logic [MAN_W:0]    sig;
    logic              guard, sticky, rnd;
    logic [MAN_W+1:0]  sig_rnd;
    logic signed [9:0] exp_adj, exp_fin;
    logic [MAN_W-1:0]  man_fin;
    logic [31:0]       norm_y;
    logic              norm_o;

    assign fa      = a;
    assign fb      = b;
    assign ca      = classify(fa.exp, fa.man);
    assign cb      = classify(fb.exp, fb.man);
    assign sign_in = fa.sign ^ fb.sign;
    assign accept  = in_valid && in_ready;

    fdiv_mant_core #(.QBITS_P(QBITS)) u_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (core_start),
        .dividend_i ({1'b1, fa.man}),
        .divisor_i  ({1'b1, fb.man}),
        .busy_o     (core_busy),
        .done_o     (core_done),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always_comb begin
        spec_hit = 1'b1;
        spec_c   = 1'b0;
        spec_y   = {sign_in, 31'b0};
        if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
            spec_y = QNAN;
        end else if (ca.inf) begin
            spec_y = {sign_in, POS_INF[30:0]};
        end else if (cb.zero) begin
            spec_y = {sign_in, POS_INF[30:0]};
            spec_c = 1'b1;
        end else if (!(ca.zero || cb.inf)) begin
            spec_hit = 1'b0;
        end
    end

    // Quotient of two [1,2) significands lies in (0.5,2); q[25]=0 means one normalising shift.
    always_comb begin
        sig     = quot[QBITS-1 -: MAN_W+1];
        guard   = quot[QBITS-MAN_W-2];
        sticky  = quot[0] | (|rem);
        exp_adj = exp_q;
        if (!quot[QBITS-1]) begin
            sig     = quot[QBITS-2 -: MAN_W+1];
            guard   = quot[0];
            sticky  = |rem;
            exp_adj = exp_q - 10'sd1;
        end
        rnd     = round_increment(sig[0], guard, sticky);
        sig_rnd = {1'b0, sig} + {{(MAN_W+1){1'b0}}, rnd};
        exp_fin = exp_adj;
        man_fin = sig_rnd[MAN_W-1:0];
        if (sig_rnd[MAN_W+1]) begin
            exp_fin = exp_adj + 10'sd1;
            man_fin = sig_rnd[MAN_W:1];
        end
        norm_o = 1'b1;
        if (exp_fin >= EXP_MAX) begin
            norm_y = {sign_q, POS_INF[30:0]};
        end else if (exp_fin <= 10'sd0) begin
            norm_y = {sign_q, 31'b0};
        end else begin
            norm_o = 1'b0;
            norm_y = {sign_q, exp_fin[EXP_W-1:0], man_fin};
        end
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        y_d        = y_q;
        z_d        = z_q;
        n_d        = n_q;
        c_d        = c_q;
        o_d        = o_q;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d = sign_in;
                    exp_d  = $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp})
                           + $signed(10'(BIAS));
                    if (spec_hit) begin
                        y_d     = spec_y;
                        z_d     = (spec_y[30:0] == '0);
                        n_d     = spec_y[31];
                        c_d     = spec_c;
                        o_d     = 1'b0;
                        state_d = DONE;
                    end else begin
                        core_start = 1'b1;
                        state_d    = DIVIDE;
                    end
                end
            end
            DIVIDE: if (core_done) state_d = NORM;
            NORM: begin
                y_d     = norm_y;
                z_d     = (norm_y[30:0] == '0);
                n_d     = norm_y[31];
                c_d     = 1'b0;
                o_d     = norm_o;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            o_q     <= o_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
    end

    assign in_ready  = (state_q == IDLE) && !rst && !core_busy;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign o         = o_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: scoreboard bench for fdiv_seq; hand-derived quotients, latency, hold and abort.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        z, n, c, o;

    localparam logic [3:0] F_Z = 4'b1000;
    localparam logic [3:0] F_N = 4'b0100;
    localparam logic [3:0] F_C = 4'b0010;
    localparam logic [3:0] F_O = 4'b0001;

`ifdef FDIV_ROUND_NEAREST_EN
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  f;
        logic [7:0]  lat;
        logic [7:0]  hold;
    } vec_t;

    vec_t        vecs[$];
    logic [35:0] sb_q[$];
    int          n_vec = 0;
    int          n_mis = 0;

    fdiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .z         (z),
        .n         (n),
        .c         (c),
        .o         (o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic add(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vy,
                       input logic [3:0] vf, input int vlat, input int vhold);
        vecs.push_back({va, vb, vy, vf, 8'(vlat), 8'(vhold)});
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int          t;
        int          lat;
        logic [35:0] got;
        logic [35:0] want;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
        sb_q.push_back({v.y, v.f});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("v%0d_busy", idx), 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
        got  = {y, z, n, c, o};
        want = '1;
        if (sb_q.size() > 0) want = sb_q.pop_front();
        check($sformatf("v%0d_result", idx), 64'(got), 64'(want));
        for (int h = 0; h < int'(v.hold); h++) begin
            @(negedge clk);
            check($sformatf("v%0d_hold%0d", idx, h), 64'({out_valid, in_ready, y, z, n, c, o}),
                  64'({2'b10, want}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("v%0d_release", idx), 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({out_valid, in_ready, y, z, n, c, o}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_ready", 64'(in_ready), 64'd1);

        add(32'h40C00000, 32'h3FC00000, 32'h40800000, 4'b0000,    28, 0);
        add(32'h3F800000, 32'h40400000, ONE_THIRD,     4'b0000,    28, 5);
        add(32'hC10AB852, 32'h410AB852, 32'hBF800000, F_N,        28, 0);
        add(32'h40A00000, 32'h00000000, 32'h7F800000, F_C,         1, 0);
        add(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0000,     1, 0);
        add(32'h7F000000, 32'h3E800000, 32'h7F800000, F_O,        28, 0);
        add(32'h40E00000, 32'h40000000, 32'h40600000, 4'b0000,    28, 0);
        add(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000,    28, 0);
        add(32'h7F000000, 32'h3F000000, 32'h7F800000, F_O,        28, 0);
        add(32'h01000000, 32'h40000000, 32'h00800000, 4'b0000,    28, 0);
        add(32'h00800000, 32'h3FC00000, 32'h00000000, F_Z | F_O,  28, 0);
        add(32'h80800000, 32'h7F000000, 32'h80000000, F_Z | F_N | F_O, 28, 0);
        add(32'hFF800000, 32'h40000000, 32'hFF800000, F_N,         1, 0);
        add(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0000,     1, 0);
        add(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000,     1, 0);
        add(32'h80000000, 32'h40A00000, 32'h80000000, F_Z | F_N,   1, 0);
        add(32'h40400000, 32'h7F800000, 32'h00000000, F_Z,         1, 0);
        add(32'h00000001, 32'h3F800000, 32'h00000000, F_Z,         1, 0);
        add(32'h40A00000, 32'h80000000, 32'hFF800000, F_N | F_C,   1, 0);
        add(32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000,     1, 0);

        foreach (vecs[i]) run_op(i, vecs[i]);

        // Abort: reset lands in the tenth DIVIDE cycle; the pending result must vanish.
        @(negedge clk);
        a        = 32'h40C00000;
        b        = 32'h3FC00000;
        in_valid = 1'b1;
        sb_q.push_back({32'h40800000, 4'b0000});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen     = out_valid;
        repeat (9) begin
            @(negedge clk);
            seen |= out_valid;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            seen |= out_valid;
            check("abort_ready_in_rst", 64'(in_ready), 64'd0);
        end
        sb_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after_rst", 64'(in_ready), 64'd1);
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("abort_no_valid", 64'(seen), 64'd0);

        run_op(99, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
